// File: rtl/data_mem_responder_pkg.sv
// -----------------------------------------------------------------------------
// data_mem_responder_pkg
//   Shared definitions for the data-memory responder slice:
//     - state_t    : 2-bit FSM encoding (IDLE / WAIT / RESP)
//     - WORD_W     : data word width in bits
//     - WORD_BYTES : bytes per storage word (sets the byte-offset field width)
//     - OFFS_W     : width of the byte-offset field inside a byte address
//     - CNT_W      : width of the request latency counter (LATENCY <= 15)
// -----------------------------------------------------------------------------
package data_mem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int WORD_W     = 32;
  localparam int WORD_BYTES = 4;
  localparam int OFFS_W     = $clog2(WORD_BYTES);
  localparam int CNT_W      = 4;

endpackage

// File: rtl/data_mem_responder_counter.sv
// -----------------------------------------------------------------------------
// latency_counter
//   Down-counter that paces a request from acceptance to response.
//   Ports:
//     clk      - clock, rising edge
//     reset    - asynchronous active-low reset, clears the count
//     load     - load load_val (takes priority over dec)
//     load_val - value loaded on load
//     dec      - decrement by one; saturates at zero
//     count    - current count
//     zero     - count == 0
// -----------------------------------------------------------------------------
module latency_counter
  import data_mem_responder_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
//   Single-outstanding word memory with a valid/ready request channel and a
//   valid/ready response channel. Each accepted request spends LATENCY cycles
//   before its response is presented; the write is committed and read data is
//   captured only on the edge that enters RESP, so an aborted request (reset
//   while waiting) leaves storage untouched. Storage is not reset.
//
//   Parameters:
//     DEPTH   - number of 32-bit words in block[]
//     LATENCY - cycles from acceptance to rsp_valid (1..15)
//   Ports:
//     clk       - clock, rising edge
//     reset     - asynchronous active-low reset
//     req_valid - request present
//     req_ready - responder can accept (registered, IDLE only)
//     req_we    - 1 = write, 0 = read
//     req_addr  - byte address, word index = req_addr[31:2]
//     req_wdata - write data
//     rsp_valid - response present (held until rsp_ready)
//     rsp_ready - initiator takes the response
//     rsp_rdata - read data; 0 for writes and errors
//     rsp_err   - misaligned or out-of-range request
// -----------------------------------------------------------------------------
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH   = 32,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int               IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LATENCY - 1);

  state_t            state;
  logic [WORD_W-1:0] block [0:DEPTH-1];

  // Latched request
  logic              p_we;
  logic [31:0]       p_addr;
  logic [WORD_W-1:0] p_wdata;

  logic              accept;
  logic              commit;
  logic              p_err;
  logic [IDX_W-1:0]  p_word;
  logic [CNT_W-1:0]  lat_count;
  logic              lat_zero;

  assign accept = (state == IDLE) && req_valid && req_ready;

  // Error covers both misalignment and any index past the end of block[];
  // the full shifted address is compared so high address bits cannot alias.
  assign p_err  = (p_addr[OFFS_W-1:0] != '0) || ((p_addr >> OFFS_W) >= 32'(DEPTH));
  assign p_word = p_addr[OFFS_W +: IDX_W];

  // The WAIT->RESP edge. state is forced to IDLE asynchronously by reset, so
  // a request interrupted by reset never reaches this point.
  assign commit = (state == WAIT) && lat_zero;

  latency_counter u_latency_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .load_val (LOAD_VAL),
    .dec      ((state == WAIT) && !lat_zero),
    .count    (lat_count),
    .zero     (lat_zero)
  );

  // ---- request capture ----
  always_ff @(posedge clk) begin
    if (accept) begin
      p_we    <= req_we;
      p_addr  <= req_addr;
      p_wdata <= req_wdata;
    end
  end

  // ---- storage write (no reset: contents survive reset) ----
  always_ff @(posedge clk) begin
    if (commit && p_we && !p_err) begin
      block[p_word] <= p_wdata;
    end
  end

  // ---- control FSM with registered outputs ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // req_ready is registered: it rises on the first edge spent in
          // IDLE, which gives the one-cycle gap after a response handshake.
          if (accept) begin
            state     <= WAIT;
            req_ready <= 1'b0;
          end else begin
            req_ready <= 1'b1;
          end
        end
        WAIT: begin
          if (lat_zero) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= p_err;
            rsp_rdata <= (p_err || p_we) ? '0 : block[p_word];
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b0;
          rsp_valid <= 1'b0;
          rsp_rdata <= '0;
          rsp_err   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  // Shared stimulus for the latency-sweep instances
  logic        s_valid = 1'b0;
  logic        s_we = 1'b0;
  logic [31:0] s_addr = '0;
  logic [31:0] s_wdata = '0;
  logic        s_rsp_ready = 1'b1;
  logic        l1_req_ready, l1_rsp_valid, l1_rsp_err;
  logic [31:0] l1_rsp_rdata;
  logic        l15_req_ready, l15_rsp_valid, l15_rsp_err;
  logic [31:0] l15_rsp_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH(32), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  data_mem_responder #(.DEPTH(32), .LATENCY(1)) u_l1 (
    .clk(clk), .reset(reset),
    .req_valid(s_valid), .req_ready(l1_req_ready), .req_we(s_we),
    .req_addr(s_addr), .req_wdata(s_wdata),
    .rsp_valid(l1_rsp_valid), .rsp_ready(s_rsp_ready),
    .rsp_rdata(l1_rsp_rdata), .rsp_err(l1_rsp_err)
  );

  data_mem_responder #(.DEPTH(32), .LATENCY(15)) u_l15 (
    .clk(clk), .reset(reset),
    .req_valid(s_valid), .req_ready(l15_req_ready), .req_we(s_we),
    .req_addr(s_addr), .req_wdata(s_wdata),
    .rsp_valid(l15_rsp_valid), .rsp_ready(s_rsp_ready),
    .rsp_rdata(l15_rsp_rdata), .rsp_err(l15_rsp_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] val(input int i);
    if (i == 3) return 32'h0000_0100;
    if (i == 9) return 32'h0000_0099;
    return 32'hA5A5_0000 + 32'(i);
  endfunction

  // ---------------------------------------------------------------------------
  // Transaction-level reference: a word array plus the cycle numbers at which
  // each response appears and the request channel reopens.
  // ---------------------------------------------------------------------------
  logic [31:0] mem [0:31];
  int          cyc;
  int          m_ready_at;
  int          m_rsp_at;
  bit          m_busy, m_rsp_on, m_from_reset, m_rdy_b;
  bit          p_we;
  logic [31:0] p_addr, p_wdata;
  logic [31:0] m_rdata;
  bit          m_err;

  initial begin : model
    m_busy = 0; m_rsp_on = 0; m_from_reset = 1; cyc = 0; m_ready_at = 0;
    m_rdata = '0; m_err = 0;
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        m_busy = 0; m_rsp_on = 0; m_from_reset = 1;
      end else begin
        m_rdy_b = !m_busy && !m_from_reset && (cyc >= m_ready_at);
        cyc++;
        if (m_from_reset) begin
          m_from_reset = 0;
          m_ready_at = cyc;
        end
        if (m_rsp_on) begin
          if (rsp_ready) begin
            m_rsp_on = 0; m_busy = 0; m_ready_at = cyc + 1;
          end
        end else if (m_busy) begin
          if (cyc == m_rsp_at) begin
            m_rsp_on = 1;
            if (p_addr[1:0] != 2'b00 || p_addr[31:2] >= 30'd32) begin
              m_err = 1; m_rdata = '0;
            end else if (p_we) begin
              mem[p_addr[6:2]] = p_wdata; m_err = 0; m_rdata = '0;
            end else begin
              m_err = 0; m_rdata = mem[p_addr[6:2]];
            end
          end
        end else if (m_rdy_b && req_valid) begin
          m_busy = 1; m_rsp_at = cyc + LAT;
          p_we = req_we; p_addr = req_addr; p_wdata = req_wdata;
        end
      end
    end
  end

  initial begin : compare
    forever begin
      @(negedge clk);
      if (!reset) begin
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      end else begin
        chk("req_ready", 32'(req_ready), 32'(!m_busy && !m_from_reset && cyc >= m_ready_at));
        chk("rsp_valid", 32'(rsp_valid), 32'(m_rsp_on));
        if (m_rsp_on) begin
          chk("rsp_rdata", rsp_rdata, m_rdata);
          chk("rsp_err", 32'(rsp_err), 32'(m_err));
        end
      end
    end
  end

  task automatic xact(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                      input int hold, input bit early, input logic [31:0] hold_rd,
                      output logic [31:0] rd, output logic er, output int lat);
    int k;
    rd = '0; er = 1'b0; lat = -1;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    if (early) rsp_ready = 1'b1;
    k = 0;
    while (!req_ready && k < 50) begin @(negedge clk); k++; end
    if (!req_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      req_valid = 1'b0; rsp_ready = 1'b0;
      return;
    end
    @(negedge clk);
    req_valid = 1'b0;
    k = 0;
    while (!rsp_valid && k < 40) begin @(negedge clk); k++; end
    if (!rsp_valid) begin
      chk("rsp_timeout", 32'd0, 32'd1);
      rsp_ready = 1'b0;
      return;
    end
    lat = k; rd = rsp_rdata; er = rsp_err;
    if (!early) begin
      for (int j = 0; j < hold; j++) begin
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h0C; req_wdata = 32'hBAD;
        @(negedge clk);
        chk("hold_valid", 32'(rsp_valid), 32'd1);
        chk("hold_rdata", rsp_rdata, hold_rd);
        chk("hold_req_ready", 32'(req_ready), 32'd0);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
    end
    @(negedge clk);
    rsp_ready = 1'b0;
    if (hold > 0) begin
      chk("ready_at_hs", 32'(req_ready), 32'd0);
      @(negedge clk);
      chk("ready_after_hs", 32'(req_ready), 32'd1);
    end
  endtask

  task automatic sweep(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                       output int lat1, output int lat15,
                       output logic [31:0] rd1, output logic [31:0] rd15);
    int k;
    lat1 = -1; lat15 = -1; rd1 = '0; rd15 = '0;
    @(negedge clk);
    k = 0;
    while (!(l1_req_ready && l15_req_ready) && k < 40) begin @(negedge clk); k++; end
    if (!(l1_req_ready && l15_req_ready)) begin
      chk("sweep_accept_timeout", 32'd0, 32'd1);
      return;
    end
    s_valid = 1'b1; s_we = we; s_addr = addr; s_wdata = wdata;
    @(negedge clk);
    s_valid = 1'b0;
    for (int j = 0; j < 40; j++) begin
      if (l1_rsp_valid && lat1 < 0) begin lat1 = j; rd1 = l1_rsp_rdata; end
      if (l15_rsp_valid && lat15 < 0) begin lat15 = j; rd15 = l15_rsp_rdata; end
      if (lat1 >= 0 && lat15 >= 0) break;
      @(negedge clk);
    end
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [31:0] rd, rd1, rd15;
    logic        er;
    int          lat, lat1, lat15;

    @(negedge clk);
    chk("reset_req_ready", 32'(req_ready), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_rdata", rsp_rdata, 32'd0);
    chk("reset_rsp_err", 32'(rsp_err), 32'd0);
    #2 reset = 1'b1;
    @(negedge clk);
    chk("ready_first_edge", 32'(req_ready), 32'd1);

    for (int i = 0; i < 32; i++) begin
      xact(1'b1, 32'(i * 4), val(i), 0, 1'b0, '0, rd, er, lat);
      chk("preload_rdata", rd, 32'd0);
      chk("preload_err", 32'(er), 32'd0);
      chk("preload_lat", 32'(lat), 32'd2);
    end

    xact(1'b0, 32'h0C, '0, 0, 1'b0, '0, rd, er, lat);
    chk("read_0C_rdata", rd, 32'h100);
    chk("read_0C_err", 32'(er), 32'd0);
    chk("read_0C_lat", 32'(lat), 32'd2);

    xact(1'b1, 32'h14, 32'h150, 0, 1'b0, '0, rd, er, lat);
    chk("write_14_rdata", rd, 32'd0);
    chk("write_14_err", 32'(er), 32'd0);
    xact(1'b0, 32'h14, '0, 0, 1'b0, '0, rd, er, lat);
    chk("raw_14_rdata", rd, 32'h150);

    xact(1'b0, 32'h0D, '0, 0, 1'b0, '0, rd, er, lat);
    chk("misaligned_err", 32'(er), 32'd1);
    chk("misaligned_rdata", rd, 32'd0);
    xact(1'b1, 32'h80, 32'hFFFF, 0, 1'b0, '0, rd, er, lat);
    chk("oor_write_err", 32'(er), 32'd1);
    chk("oor_write_rdata", rd, 32'd0);
    xact(1'b1, 32'h12, 32'hDEAD, 0, 1'b0, '0, rd, er, lat);
    chk("misaligned_write_err", 32'(er), 32'd1);
    xact(1'b0, 32'h00, '0, 0, 1'b0, '0, rd, er, lat);
    chk("block0_intact", rd, 32'hA5A5_0000);
    xact(1'b0, 32'h10, '0, 0, 1'b0, '0, rd, er, lat);
    chk("block4_intact", rd, 32'hA5A5_0004);
    xact(1'b0, 32'h7C, '0, 0, 1'b0, '0, rd, er, lat);
    chk("block31_intact", rd, 32'hA5A5_001F);

    // rsp_ready already high during IDLE/WAIT
    xact(1'b0, 32'h14, '0, 0, 1'b1, '0, rd, er, lat);
    chk("early_ready_rdata", rd, 32'h150);
    chk("early_ready_lat", 32'(lat), 32'd2);

    // Backpressure with a competing request presented while busy
    xact(1'b0, 32'h0C, '0, 5, 1'b0, 32'h100, rd, er, lat);
    chk("bp_rdata", rd, 32'h100);
    xact(1'b0, 32'h0C, '0, 0, 1'b0, '0, rd, er, lat);
    chk("ignored_req_no_write", rd, 32'h100);

    // Reset while a write is waiting
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h24; req_wdata = 32'h1FF;
    for (int k = 0; k < 50 && !req_ready; k++) @(negedge clk);
    chk("midop_accept", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("midop_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midop_rsp_rdata", rsp_rdata, 32'd0);
    chk("midop_rsp_err", 32'(rsp_err), 32'd0);
    chk("midop_req_ready", 32'(req_ready), 32'd0);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    chk("midop_ready_after_release", 32'(req_ready), 32'd1);
    xact(1'b0, 32'h24, '0, 0, 1'b0, '0, rd, er, lat);
    chk("midop_block9_kept", rd, 32'h99);
    xact(1'b0, 32'h20, '0, 0, 1'b0, '0, rd, er, lat);
    chk("block8_read", rd, 32'hA5A5_0008);

    // Latency sweep
    sweep(1'b1, 32'h08, 32'hABC, lat1, lat15, rd1, rd15);
    chk("l1_write_lat", 32'(lat1), 32'd1);
    chk("l15_write_lat", 32'(lat15), 32'd15);
    sweep(1'b0, 32'h08, '0, lat1, lat15, rd1, rd15);
    chk("l1_read_lat", 32'(lat1), 32'd1);
    chk("l15_read_lat", 32'(lat15), 32'd15);
    chk("l1_read_rdata", rd1, 32'hABC);
    chk("l15_read_rdata", rd15, 32'hABC);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 32, meaning the number of 32-bit words in the storage array.
REQ-002 SHALL have parameter LATENCY, default 2, meaning the cycles from request acceptance to response valid (range 1..15).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates occur on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = reset asserted).
REQ-005 SHALL have port req_valid, input, 1 bit: the initiator presents a request.
REQ-006 SHALL have port req_ready, output, 1 bit: the responder can accept a request.
REQ-007 SHALL have port req_we, input, 1 bit: 1 = write, 0 = read.
REQ-008 SHALL have port req_addr, input, 32 bits: byte address; word index = req_addr[31:2].
REQ-009 SHALL have port req_wdata, input, 32 bits: the write data.
REQ-010 SHALL have port rsp_valid, output, 1 bit: a response is presented.
REQ-011 SHALL have port rsp_ready, input, 1 bit: the initiator accepts the response.
REQ-012 SHALL have port rsp_rdata, output, 32 bits: read data; 0 for writes and errors.
REQ-013 SHALL have port rsp_err, output, 1 bit: the request was misaligned or out of range.

Function
REQ-014 SHALL hold storage in an array named block[0:DEPTH-1] of 32-bit words that is loadable by hierarchical $readmemh.
REQ-015 SHALL implement the FSM states IDLE, WAIT and RESP.
REQ-016 SHALL assert req_ready only in IDLE; a request is accepted when req_valid && req_ready on a clock edge.
REQ-017 On acceptance, SHALL latch we/addr/wdata and go IDLE->WAIT with the latency counter loaded to LATENCY-1.
REQ-018 In WAIT, SHALL decrement the counter each cycle and go WAIT->RESP on the edge where the counter equals 0, so that rsp_valid rises exactly LATENCY cycles after acceptance.
REQ-019 SHALL perform the write (block[idx] <= wdata) and capture read data only on the WAIT->RESP edge, never earlier.
REQ-020 SHALL flag an error when addr[1:0] != 0 or idx >= DEPTH; an errored request SHALL NOT modify block, and SHALL set rsp_err=1 and rsp_rdata=0.
REQ-021 SHALL hold rsp_valid, rsp_rdata and rsp_err stable in RESP until rsp_ready=1; on that edge it SHALL go RESP->IDLE.
REQ-022 SHALL NOT accept a new request in the same cycle as a response handshake (no back-to-back overlap); req_ready rises one cycle after rsp handshake.
REQ-023 A read following a write to the same word SHALL return the newly written value.
REQ-024 SHALL ignore req_* inputs outside IDLE.
REQ-025 rsp_ready asserted outside RESP SHALL have no effect.

Reset
REQ-026 When reset=0, SHALL immediately (asynchronously) set state=IDLE, counter=0, req_ready=0 while reset is held, and rsp_valid=0, rsp_rdata=0, rsp_err=0.
REQ-027 After reset deasserts, SHALL raise req_ready at the first clock edge.
REQ-028 SHALL NOT clear block contents on reset.
REQ-029 Reset during WAIT SHALL abort the request; its pending write SHALL NOT be committed.

Structure
REQ-030 SHALL place the FSM state encodings (2-bit) and the word-size constant in a shared package/include file used by the memory-stage modules.
REQ-031 SHALL use one sub-module, latency_counter (load/decrement/zero flag), instantiated once; storage and FSM live in data_mem_responder.

Verification
REQ-032 Read test: block[3]=0x100 preloaded, read addr 0x0C -> rsp_valid exactly 2 cycles after acceptance, rdata=0x100, err=0.
REQ-033 Write-then-read test: write 0x150 to addr 0x14, then read 0x14 -> write response rdata=0, err=0; read response rdata=0x150.
REQ-034 Error test: read addr 0x0D -> err=1, rdata=0; write 0xFFFF to addr 0x80 (idx 32) -> err=1, and block contents are unchanged.
REQ-035 Backpressure test: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_valid/rdata held constant, req_ready=0 throughout; req_ready=1 one cycle after the handshake.
REQ-036 Reset mid-op test: write 0x1FF to addr 0x24, assert reset=0 during WAIT -> outputs cleared immediately, block[9] keeps its old value, req_ready=1 at the first edge after release.
REQ-037 Latency sweep test: LATENCY=1 and LATENCY=15 -> acceptance-to-rsp_valid distance equals LATENCY cycles.
